// File: rtl/playbus_arbiter_if.sv
// PlayBus arbiter signal bundle: two requesters, the shared PlayBus drive/state
// lines, per-requester grant/done, and FSM debug visibility.
interface playbus_arbiter_if;
  // Handshake: a requester holds REQn (with stable FUNCn/ADDn) until it sees GNTn;
  // the arbiter samples FUNCn/ADDn on the grant edge, and DONEn is a one-cycle
  // acknowledge that the granted PlayBus function has finished or timed out.
  logic       REQ0;
  logic [2:0] FUNC0;
  logic [3:0] ADD0;
  logic       REQ1;
  logic [2:0] FUNC1;
  logic [3:0] ADD1;
  logic [1:0] St;
  logic       GO;
  logic [2:0] FUNC;
  logic [3:0] ADD;
  logic       GNT0;
  logic       GNT1;
  logic       DONE0;
  logic       DONE1;
  logic       NOACK;
  logic       BUSY;
  logic [1:0] dbg_state;
  logic       dbg_ptr;
  logic [2:0] dbg_tc;

  modport slave (
    input  REQ0, FUNC0, ADD0, REQ1, FUNC1, ADD1, St,
    output GO, FUNC, ADD, GNT0, GNT1, DONE0, DONE1, NOACK, BUSY,
    output dbg_state, dbg_ptr, dbg_tc
  );

  modport master (
    output REQ0, FUNC0, ADD0, REQ1, FUNC1, ADD1, St,
    input  GO, FUNC, ADD, GNT0, GNT1, DONE0, DONE1, NOACK, BUSY,
    input  dbg_state, dbg_ptr, dbg_tc
  );
endinterface

// File: rtl/playbus_arbiter.sv
// Two-requester round-robin arbiter for the PlayBus: grants one requester,
// issues GO with a bounded start timeout, waits out the function, then releases.
module playbus_arbiter (
  input  logic              CK2HZ,
  input  logic              CLR,
  playbus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t     state_q, state_n;
  logic [2:0] func_q, func_n;
  logic [3:0] add_q, add_n;
  logic       gnt0_q, gnt0_n;
  logic       gnt1_q, gnt1_n;
  logic       done0_q, done0_n;
  logic       done1_q, done1_n;
  logic       noack_q, noack_n;
  logic       ptr_q, ptr_n;
  logic       win_q, win_n;
  logic [2:0] tc_q, tc_n;
  logic       win_sel;
  logic       st_idle;

  assign st_idle = (bus.St == 2'd0);

  always_ff @(posedge CK2HZ or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      func_q  <= 3'd0;
      add_q   <= 4'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      noack_q <= 1'b0;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      tc_q    <= 3'd0;
    end else begin
      state_q <= state_n;
      func_q  <= func_n;
      add_q   <= add_n;
      gnt0_q  <= gnt0_n;
      gnt1_q  <= gnt1_n;
      done0_q <= done0_n;
      done1_q <= done1_n;
      noack_q <= noack_n;
      ptr_q   <= ptr_n;
      win_q   <= win_n;
      tc_q    <= tc_n;
    end
  end

  always_comb begin
    state_n = state_q;
    func_n  = func_q;
    add_n   = add_q;
    gnt0_n  = gnt0_q;
    gnt1_n  = gnt1_q;
    done0_n = 1'b0;
    done1_n = 1'b0;
    noack_n = noack_q;
    ptr_n   = ptr_q;
    win_n   = win_q;
    tc_n    = tc_q;
    // A lone requester wins outright; PTR only breaks a tie.
    win_sel = (bus.REQ0 && bus.REQ1) ? ptr_q : bus.REQ1;

    case (state_q)
      IDLE: begin
        // Never start a grant while the bus is still busy, so GO cannot meet St != 0.
        if ((bus.REQ0 || bus.REQ1) && st_idle) begin
          win_n   = win_sel;
          func_n  = win_sel ? bus.FUNC1 : bus.FUNC0;
          add_n   = win_sel ? bus.ADD1  : bus.ADD0;
          gnt0_n  = ~win_sel;
          gnt1_n  = win_sel;
          tc_n    = 3'd0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        tc_n = tc_q + 3'd1;
        if (!st_idle) begin
          state_n = RUN;
        end else if (tc_q == 3'd3) begin
          // Fourth GO cycle with no start: give up.
          noack_n = 1'b1;
          done0_n = ~win_q;
          done1_n = win_q;
          state_n = RELEASE;
        end
      end
      RUN: begin
        if (st_idle) begin
          noack_n = 1'b0;
          done0_n = ~win_q;
          done1_n = win_q;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (st_idle) begin
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
          ptr_n   = ~win_q;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.GO        = (state_q == ISSUE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.FUNC      = func_q;
  assign bus.ADD       = add_q;
  assign bus.GNT0      = gnt0_q;
  assign bus.GNT1      = gnt1_q;
  assign bus.DONE0     = done0_q;
  assign bus.DONE1     = done1_q;
  assign bus.NOACK     = noack_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_tc    = tc_q;

endmodule

// File: doc/playbus_arbiter.md
PLAYBUS_ARBITER -- requirements
Module: playbus_arbiter

Interface
REQ-001 The block SHALL have the port CK2HZ, input, 1 bit: the system clock, rising-edge active.
REQ-002 The block SHALL have the port CLR, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the port REQ0, input, 1 bit: requester 0 asks to run a PlayBus function.
REQ-004 The block SHALL have the ports FUNC0 (input, 3 bits) and ADD0 (input, 4 bits): requester 0's function code and address.
REQ-005 The block SHALL have the ports REQ1 (input, 1 bit), FUNC1 (input, 3 bits) and ADD1 (input, 4 bits): the same signals for requester 1.
REQ-006 The block SHALL have the port St, input, 2 bits: PlayBus state; 0 means idle and any non-zero value means a function is executing.
REQ-007 The block SHALL have the ports GO (output, 1 bit), FUNC (output, 3 bits) and ADD (output, 4 bits), which drive the PlayBus.
REQ-008 The block SHALL have the ports GNT0 and GNT1, outputs, 1 bit each: that requester owns the PlayBus.
REQ-009 The block SHALL have the ports DONE0 and DONE1, outputs, 1 bit each: a one-cycle completion pulse to that requester.
REQ-010 The block SHALL have the port NOACK, output, 1 bit: the last transaction timed out without the PlayBus starting.
REQ-011 The block SHALL have the port BUSY, output, 1 bit: the arbiter is in any state other than IDLE.

Function
REQ-012 The arbiter SHALL be a registered FSM with the states IDLE, ISSUE, RUN and RELEASE, and all outputs SHALL be registered or decoded from state only.
REQ-013 In IDLE with REQ0=1 or REQ1=1, the arbiter SHALL select a winner using a 1-bit round-robin pointer PTR, where PTR=0 means requester 0 has priority.
REQ-014 On that same edge, the arbiter SHALL latch the winner's FUNC/ADD into the FUNC/ADD output registers, set the winner's GNT, and go to ISSUE.
REQ-015 If only one requester is asserting REQ, that requester SHALL win regardless of PTR.
REQ-016 FUNC and ADD SHALL remain stable from the grant edge until the next grant, so requester input changes during a transaction have no effect.
REQ-017 In ISSUE, GO SHALL be 1 and a 3-bit timeout counter TC SHALL increment each cycle, starting from 0 on ISSUE entry.
REQ-018 In ISSUE, when St != 0 is sampled, the arbiter SHALL go to RUN, and GO SHALL be 0 from that edge.
REQ-019 In ISSUE, when TC reaches 4 with St still 0, the arbiter SHALL set NOACK=1 and go to RELEASE; GO SHALL therefore be held for at most 4 cycles.
REQ-020 In RUN, GO SHALL be 0, and when St = 0 is sampled the arbiter SHALL set NOACK=0 and go to RELEASE.
REQ-021 RUN SHALL have no timeout; the PlayBus function length is unbounded.
REQ-022 In RELEASE, the winner's DONE SHALL be 1 for exactly one cycle.
REQ-023 On the edge leaving RELEASE, the arbiter SHALL clear both GNT0 and GNT1, set PTR to the non-winner, and return to IDLE.
REQ-024 The minimum transaction length SHALL be IDLE→ISSUE→RUN→RELEASE→IDLE, i.e. GNT is high for at least 3 cycles.
REQ-025 If the granted REQ falls mid-transaction, the transaction SHALL complete normally, because a PlayBus function cannot be aborted, and DONE SHALL still pulse.
REQ-026 A requester whose REQ stays high after its DONE SHALL be eligible again only in the IDLE cycle, subject to PTR.
REQ-027 Because of REQ-026, with both requesters continuously requesting, grants SHALL strictly alternate 0,1,0,1...
REQ-028 GNT0 and GNT1 SHALL never both be 1, and DONE0 and DONE1 SHALL never both be 1.
REQ-029 NOACK SHALL hold its value until the next RELEASE updates it.
REQ-030 In RELEASE, if St is non-zero, the arbiter SHALL stay in RELEASE until St = 0; DONE SHALL pulse only on the first RELEASE cycle.
REQ-031 The block SHALL NOT assert GO while St != 0.

Reset
REQ-032 While CLR=1, the outputs SHALL be: state=IDLE, GO=0, FUNC=0, ADD=0, GNT0=GNT1=0, DONE0=DONE1=0, NOACK=0, BUSY=0, PTR=0, TC=0.
REQ-033 Assertion of CLR mid-transaction SHALL take effect immediately, with no clock needed, and SHALL NOT produce a DONE pulse.
REQ-034 After CLR is released, the first grant SHALL favour requester 0.

Verification
REQ-035 Single request: REQ0=1, FUNC0=5, ADD0=3; St goes to 1 two cycles after GO, then back to 0 after 6 cycles → GNT0=1 with FUNC=5 and ADD=3, GO high for 2 cycles, then DONE0 pulses once, NOACK=0, and GNT0 drops.
REQ-036 Contention: REQ0=REQ1=1 held continuously with St emulated → grant order is 0,1,0,1; GNT0 and GNT1 never overlap; FUNC/ADD switch only on grant edges.
REQ-037 Timeout: REQ1=1, FUNC1=2, St held at 0 → GO high for exactly 4 cycles, then DONE1 pulses, NOACK=1, and the arbiter returns to IDLE.
REQ-038 Request withdrawn: REQ0 pulses high for 1 cycle; then FUNC0 changes while St=2 → transaction completes with the latched FUNC, and DONE0 pulses.
REQ-039 Reset mid-RUN: CLR=1 while St=3 → all outputs reach their reset values before the next clock edge, and no DONE pulse occurs.
REQ-040 Stuck St: St non-zero on entry to RELEASE → DONE pulses once, and the next grant waits until St=0.
